dns_request_queue: RTL and testbench

//  Upstream front end of the DNS lookup FSM. Buffers client web-address requests in a FIFO and issues them one at a time.

---
 rtl/dns_pkg.sv | 17 +
 rtl/dnsq_fifo.sv | 54 +++++
 rtl/dns_request_queue.sv | 147 ++++++++++++++
 tb/tb_dns_request_queue.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dns_pkg.sv
// Shared state encoding and bus widths for the DNS request queue.
package dns_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RES,
    GET_TIME,
    RESPOND,
    FLUSH
  } dnsq_state_t;

  localparam int ADDR_W_C = 8;
  localparam int IDX_W_C  = 16;
  localparam int TIME_W_C = 8;

endpackage

// File: rtl/dnsq_fifo.sv
// DEPTH x WIDTH synchronous FIFO with first-word-fall-through read data; zero-latency pop.
// Pushes while full and pops while empty are ignored, so the caller's push stalls on full.
module dnsq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full/empty come from the registered count, so push+pop while full does not push
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dns_request_queue.sv
// Queues client address requests and runs one DNS lookup at a time; client_res to resp_valid is 2 cycles.
// Response held until resp_ready; DNSQ_TIMEOUT_EN adds a WAIT_RES watchdog and a FLUSH state.
module dns_request_queue
  import dns_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = ADDR_W_C,
  parameter int IDX_W  = IDX_W_C
`ifdef DNSQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                client_req,
  output logic [ADDR_W-1:0]   web_addr,
  input  logic                client_res,
  input  logic [IDX_W-1:0]    webpage_idx_in,
  input  logic [TIME_W_C-1:0] exec_time_in,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [ADDR_W-1:0]   resp_addr,
  output logic [IDX_W-1:0]    resp_idx,
  output logic [TIME_W_C-1:0] resp_time,
  output logic                resp_err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  dnsq_state_t       state_q;
  dnsq_state_t       state_d;
  logic [ADDR_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;
  logic              resp_accept;

  assign req_ready   = !fifo_full;
  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign resp_accept = resp_valid && resp_ready;

  dnsq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_valid),
    .push_dat (req_addr),
    .pop      (pop),
    .pop_dat  (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) assert ((fifo_empty == (fifo_count == '0)) && (fifo_full == (fifo_count == CNT_W'(DEPTH))));
  end

`ifdef DNSQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       timeout;
  logic       flush_done;

  assign timeout    = (state_q == WAIT_RES) && !client_res && (wait_cnt == TO_LAST);
  assign flush_done = client_res || (wait_cnt == TO_LAST);

  // Counter restarts on every state change, which covers entry to both WAIT_RES and FLUSH
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      resp_err <= 1'b0;
    end else begin
      wait_cnt <= (state_d != state_q) ? 8'd0 : wait_cnt + 8'd1;
      if ((state_q == WAIT_RES) && client_res) resp_err <= 1'b0;
      if (timeout) resp_err <= 1'b1;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    client_req = 1'b0;
    case (state_q)
      IDLE:     if (!fifo_empty) state_d = ISSUE;
      ISSUE: begin
        client_req = 1'b1;
        state_d    = WAIT_RES;
      end
      WAIT_RES: begin
        if (client_res) state_d = GET_TIME;
`ifdef DNSQ_TIMEOUT_EN
        else if (timeout) state_d = FLUSH;
`endif
      end
      GET_TIME: state_d = RESPOND;
      RESPOND:  if (resp_accept) state_d = IDLE;
`ifdef DNSQ_TIMEOUT_EN
      // An error response may already be taken while the late completion is absorbed
      FLUSH:    if (flush_done) state_d = (resp_valid && !resp_ready) ? RESPOND : IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      web_addr   <= '0;
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_idx   <= '0;
      resp_time  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) web_addr <= fifo_dout;
      if ((state_q == WAIT_RES) && client_res) begin
        resp_idx  <= webpage_idx_in;
        resp_addr <= web_addr;
      end
      if (state_q == GET_TIME) begin
        resp_time  <= exec_time_in;
        resp_valid <= 1'b1;
      end
      if ((state_q == RESPOND) && resp_accept) resp_valid <= 1'b0;
`ifdef DNSQ_TIMEOUT_EN
      if (timeout) begin
        resp_idx   <= '0;
        resp_time  <= '1;
        resp_addr  <= web_addr;
        resp_valid <= 1'b1;
      end
      if ((state_q == FLUSH) && resp_accept) resp_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_dns_request_queue.sv
// Bench for dns_request_queue: table-driven single lookups, then queueing, backpressure, reset and wrap sequences.
module tb_dns_request_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  logic        client_res = 1'b0;
  logic [15:0] webpage_idx_in = 16'hDEAD;
  logic [7:0]  exec_time_in = 8'hEE;
  logic        resp_ready = 1'b0;
  logic        req_ready, client_req, resp_valid, resp_err;
  logic [7:0]  web_addr, resp_addr, resp_time;
  logic [15:0] resp_idx;

  always #5 clk = ~clk;

  dns_request_queue dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .client_req     (client_req),
    .web_addr       (web_addr),
    .client_res     (client_res),
    .webpage_idx_in (webpage_idx_in),
    .exec_time_in   (exec_time_in),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_addr      (resp_addr),
    .resp_idx       (resp_idx),
    .resp_time      (resp_time),
    .resp_err       (resp_err)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] idx;
    logic [7:0]  tim;
    logic        err;
  } exp_t;

  typedef struct {
    logic [7:0]  addr;
    int          lat;
    int          rdy;
    logic [15:0] idx;
    logic [7:0]  tim;
  } vec_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         creq_cnt = 0;
  int         creq_cyc = 0;
  int         res_cyc = 0;
  int         stub_n = 4;
  bit         stub_quiet = 1'b0;
  bit         web_ok = 1'b1;
  logic [7:0] stub_a;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] f_idx(input logic [7:0] a);
    return (a == 8'h2A) ? 16'h0400 : {a, ~a};
  endfunction

  function automatic logic [7:0] f_time(input logic [7:0] a);
    return (a == 8'h2A) ? 8'd12 : (a ^ 8'h5A);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Lookup stub: client_res N cycles after client_req, exec_time one cycle later
  initial forever begin
    @(negedge clk);
    if (client_req) begin
      stub_a = web_addr;
      repeat (stub_n) begin
        @(negedge clk);
        if (!stub_quiet && web_addr !== stub_a) web_ok = 1'b0;
      end
      client_res = 1'b1;
      webpage_idx_in = f_idx(stub_a);
      res_cyc = cyc;
      @(negedge clk);
      client_res = 1'b0;
      webpage_idx_in = 16'hDEAD;
      exec_time_in = f_time(stub_a);
      @(negedge clk);
      exec_time_in = 8'hEE;
    end
  end

  // Response monitor: every accepted response is checked against the scoreboard head
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (client_req) begin
      creq_cnt++;
      creq_cyc = cyc;
    end
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("resp_unexpected", {24'h0, resp_addr}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("resp_addr", {24'h0, resp_addr}, {24'h0, e.addr});
        chk("resp_idx",  {16'h0, resp_idx},  {16'h0, e.idx});
        chk("resp_time", {24'h0, resp_time}, {24'h0, e.tim});
        chk("resp_err",  {31'h0, resp_err},  {31'h0, e.err});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [7:0] a, input exp_t e);
    int t = 0;
    req_valid = 1'b1;
    req_addr  = a;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("push_wait", t, 0);
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic push_std(input logic [7:0] a);
    push_exp(a, '{addr: a, idx: f_idx(a), tim: f_time(a), err: 1'b0});
  endtask

  task automatic wait_valid(output int c);
    int t = 0;
    while (!resp_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) chk("resp_valid_wait", t, 0);
    c = cyc;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("drain_wait", sb.size(), 0);
  endtask

  initial begin
    vec_t       vt[4];
    int         c, pc, n0;
    bit         stable, seen;
    logic [7:0] s_addr, s_time;
    logic [15:0] s_idx;

    vt[0] = '{addr: 8'h2A, lat: 10, rdy: 0, idx: 16'h0400, tim: 8'h0C};
    vt[1] = '{addr: 8'h81, lat: 1,  rdy: 3, idx: 16'h817E, tim: 8'hDB};
    vt[2] = '{addr: 8'hFF, lat: 5,  rdy: 0, idx: 16'hFF00, tim: 8'hA5};
    vt[3] = '{addr: 8'h00, lat: 2,  rdy: 1, idx: 16'h00FF, tim: 8'h5A};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("rst_client_req", {31'h0, client_req}, 32'h0);
    chk("rst_web_addr",   {24'h0, web_addr},   32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_dat",   {resp_addr, resp_idx, resp_time}, 32'h0);
    chk("rst_resp_err",   {31'h0, resp_err},   32'h0);

    // Single lookups with varying stub latency and response backpressure
    for (int i = 0; i < 4; i++) begin
      stub_n = vt[i].lat;
      n0 = creq_cnt;
      web_ok = 1'b1;
      pc = cyc;
      push_exp(vt[i].addr, '{addr: vt[i].addr, idx: vt[i].idx, tim: vt[i].tim, err: 1'b0});
      wait_valid(c);
      chk("push_to_creq", creq_cyc - pc, 2);
      chk("res_to_valid", c - res_cyc, 2);
      repeat (vt[i].rdy) @(negedge clk);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("creq_pulses", creq_cnt - n0, 1);
      chk("web_addr_held", {31'h0, web_ok}, 32'h1);
    end
    chk("vec_drained", sb.size(), 0);

    // Fill behind an outstanding lookup, then hold the response
    stub_n = 10;
    push_std(8'h10);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) push_std(8'h11 + 8'(k));
    chk("full_after_4", {31'h0, req_ready}, 32'h0);
    req_valid = 1'b1;
    req_addr  = 8'h15;
    wait_valid(c);
    s_addr = resp_addr; s_idx = resp_idx; s_time = resp_time;
    n0 = creq_cnt;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!resp_valid || resp_addr !== s_addr || resp_idx !== s_idx || resp_time !== s_time) stable = 1'b0;
    end
    chk("hold_stable", {31'h0, stable}, 32'h1);
    chk("hold_no_creq", creq_cnt - n0, 0);
    chk("fifth_waits", {31'h0, req_ready}, 32'h0);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("idle_no_creq", {31'h0, client_req}, 32'h0);
    @(negedge clk);
    chk("pop_after_release", {31'h0, client_req}, 32'h1);
    chk("fifth_ready", {31'h0, req_ready}, 32'h1);
    sb.push_back('{addr: 8'h15, idx: f_idx(8'h15), tim: f_time(8'h15), err: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();

    // Reset in WAIT_RES with three entries queued
    stub_n = 8;
    for (int k = 0; k < 4; k++) push_std(8'h40 + 8'(k));
    c = 0;
    while (!client_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
    stub_quiet = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("mrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("mrst_req_ready",  {31'h0, req_ready},  32'h1);
    chk("mrst_fifo_count", {29'h0, dut.u_fifo.count}, 32'h0);
    chk("mrst_web_addr",   {24'h0, web_addr},   32'h0);
    n0 = creq_cnt;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("late_res_ignored", {31'h0, seen}, 32'h0);
    chk("late_res_no_creq", creq_cnt - n0, 0);
    stub_quiet = 1'b0;
    resp_ready = 1'b0;

    // Push and pop in the same cycle at count 2, then fill past the pointer wrap
    stub_n = 3;
    push_std(8'h60);
    wait_valid(c);
    push_std(8'h61);
    push_std(8'h62);
    chk("count_before_pp", {29'h0, dut.u_fifo.count}, 32'h2);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 8'h63;
    sb.push_back('{addr: 8'h63, idx: f_idx(8'h63), tim: f_time(8'h63), err: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    chk("push_pop_count", {29'h0, dut.u_fifo.count}, 32'h2);
    push_std(8'h64);
    push_std(8'h65);
    chk("wrap_full", {31'h0, req_ready}, 32'h0);
    chk("wrap_wr_ptr", {30'h0, dut.u_fifo.wr_ptr}, 32'h2);
    resp_ready = 1'b1;
    wait_drain();

`ifdef DNSQ_TIMEOUT_EN
    // Lookup answers only after the watchdog; the late completion is absorbed in FLUSH
    resp_ready = 1'b0;
    stub_n = 36;
    push_exp(8'h55, '{addr: 8'h55, idx: 16'h0000, tim: 8'hFF, err: 1'b1});
    wait_valid(c);
    chk("timeout_latency", c - creq_cyc, 33);
    repeat (10) @(negedge clk);
    resp_ready = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);
    stub_n = 4;
    push_std(8'h66);
    wait_drain();
`endif

    repeat (10) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
